// File: rtl/timer_pkg.sv
// Shared register-map constants and offset helpers for the machine timer.
package timer_pkg;

    typedef logic [15:0] offset_t;

    localparam offset_t MTIME_OFFSET    = 16'h0000;
    localparam offset_t PRESCALE_OFFSET = 16'h0008;
    localparam offset_t MTIMECMP_BASE   = 16'h4000;

    function automatic offset_t cmp_offset(input int unsigned idx);
        return MTIMECMP_BASE + offset_t'(idx << 3);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: counts 0..limit and pulses tick on the terminal count.
module timer_prescaler #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] limit,
    input  logic             clear,
    output logic             tick
);

    logic [Width-1:0] count_q, count_d;

    assign tick = (count_q == limit);

    always_comb begin
        count_d = count_q + Width'(1);
        if (clear || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/timer_core.sv
// Machine timer (MTIME/MTIMECMP) with registered read port and per-core interrupts.
// Optional tick prescaler is built when TIMER_PRESCALER_EN is defined.
module timer_core import timer_pkg::*; #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned NR_CORES       = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] address_i,
    input  logic                      en_i,
    input  logic                      we_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    output logic [AXI_DATA_WIDTH-1:0] data_o,
    output logic [NR_CORES-1:0]       irq_o
);

    localparam int unsigned W = AXI_DATA_WIDTH;

    offset_t       offset;
    logic          wr, rd, tick;
    logic [W-1:0]  rdata;
    logic [W-1:0]  mtime_q, mtime_d;
    logic [W-1:0]  mtimecmp_q [NR_CORES];
    logic [W-1:0]  mtimecmp_d [NR_CORES];
    logic [W-1:0]  data_q, data_d;
    logic [NR_CORES-1:0] irq_q, irq_d;

    // Only the doubleword index is decoded; byte lanes and upper bits are ignored.
    assign offset = {address_i[15:3], 3'b000};
    assign wr     = en_i && we_i;
    assign rd     = en_i && !we_i;

    logic unused_addr;
    assign unused_addr = ^{address_i[AXI_ADDR_WIDTH-1:16], address_i[2:0]};

`ifdef TIMER_PRESCALER_EN
    logic [W-1:0] prescale_q, prescale_d;
    logic         prescale_we;

    assign prescale_we = wr && (offset == PRESCALE_OFFSET);
    assign prescale_d  = prescale_we ? data_i : prescale_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    timer_prescaler #(
        .Width (W)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .limit  (prescale_q),
        .clear  (prescale_we),
        .tick   (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        rdata   = '0;
        mtime_d = tick ? mtime_q + W'(1) : mtime_q;
        if (wr && (offset == MTIME_OFFSET)) begin
            mtime_d = data_i;
        end
        if (offset == MTIME_OFFSET) begin
            rdata = mtime_q;
        end
`ifdef TIMER_PRESCALER_EN
        if (offset == PRESCALE_OFFSET) begin
            rdata = prescale_q;
        end
`endif
        for (int unsigned i = 0; i < NR_CORES; i++) begin
            mtimecmp_d[i] = mtimecmp_q[i];
            irq_d[i]      = (mtime_q >= mtimecmp_q[i]);
            if (offset == cmp_offset(i)) begin
                rdata = mtimecmp_q[i];
                if (wr) begin
                    mtimecmp_d[i] = data_i;
                end
            end
        end
        // Read data is held between reads; upstream may sample it late.
        data_d = rd ? rdata : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
            data_q  <= '0;
            irq_q   <= '0;
            for (int unsigned i = 0; i < NR_CORES; i++) begin
                mtimecmp_q[i] <= '1;
            end
        end else begin
            mtime_q <= mtime_d;
            data_q  <= data_d;
            irq_q   <= irq_d;
            for (int unsigned i = 0; i < NR_CORES; i++) begin
                mtimecmp_q[i] <= mtimecmp_d[i];
            end
        end
    end

    assign data_o = data_q;
    assign irq_o  = irq_q;

endmodule
